// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that serialises fixed-length frames from two sources
// onto a single uart_tx byte transmitter (header, payload MSB first, XOR checksum).
//
// state | meaning
// IDLE  | no frame in flight; pick a pending source
// LOAD  | register the next frame byte onto tx_din_o
// START | raise tx_start_o for the byte just loaded
// WAIT  | hold tx_din_o until uart_tx signals byte done
module uart_frame_arbiter #(
    parameter int unsigned P_NBYTES = 6,
    parameter logic [7:0]  P_SYNC   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_i,
    input  logic [8*P_NBYTES-1:0]   data0_i,
    input  logic                    req1_i,
    input  logic [8*P_NBYTES-1:0]   data1_i,
    output logic [1:0]              grant_o,
    output logic [7:0]              tx_din_o,
    output logic                    tx_start_o,
    input  logic                    tx_done_tick_i,
    output logic                    busy_o,
    output logic [7:0]              overrun0_o,
    output logic [7:0]              overrun1_o
);

    localparam int unsigned    PW       = 8 * P_NBYTES;
    localparam int unsigned    IW       = $clog2(P_NBYTES + 2);
    localparam logic [IW-1:0]  LAST_IDX = IW'(P_NBYTES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   hold0_q, hold0_d;
    logic [PW-1:0]   hold1_q, hold1_d;
    logic [1:0]      pend_q, pend_d;
    logic            last_q, last_d;
    logic [PW-1:0]   shift_q, shift_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      csum_q, csum_d;
    logic [7:0]      din_q, din_d;
    logic            start_q, start_d;
    logic [1:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic [7:0]      ovr0_q, ovr0_d;
    logic [7:0]      ovr1_q, ovr1_d;

    logic            take;
    logic            sel;
    logic            take0;
    logic            take1;
    logic [7:0]      byte_cur;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        last_d   = last_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        din_d    = din_q;
        start_d  = 1'b0;
        grant_d  = 2'b00;
        busy_d   = busy_q;
        take     = 1'b0;
        sel      = 1'b0;
        byte_cur = 8'h00;

        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    // Tie goes to whichever source was not served last
                    sel     = (pend_q == 2'b11) ? ~last_q : pend_q[1];
                    take    = 1'b1;
                    shift_d = sel ? hold1_q : hold0_q;
                    last_d  = sel;
                    grant_d = sel ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    csum_d  = 8'h00;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (idx_q == '0) begin
                    byte_cur = {P_SYNC[7:1], last_q};
                    din_d    = byte_cur;
                    csum_d   = csum_q ^ byte_cur;
                end else if (idx_q == LAST_IDX) begin
                    din_d    = csum_q;
                end else begin
                    byte_cur = shift_q[PW-1 -: 8];
                    din_d    = byte_cur;
                    csum_d   = csum_q ^ byte_cur;
                    shift_d  = shift_q << 8;
                end
                state_d = START;
            end
            START: begin
                start_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done_tick_i) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = LOAD;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign take0 = take & ~sel;
    assign take1 = take &  sel;

    // A request landing on its own selection edge re-arms pending: set wins.
    always_comb begin
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        pend_d  = pend_q;
        ovr0_d  = ovr0_q;
        ovr1_d  = ovr1_q;

        if (req0_i) begin
            hold0_d   = data0_i;
            pend_d[0] = 1'b1;
            if (pend_q[0] && !take0 && (ovr0_q != 8'hFF)) begin
                ovr0_d = ovr0_q + 8'd1;
            end
        end else if (take0) begin
            pend_d[0] = 1'b0;
        end

        if (req1_i) begin
            hold1_d   = data1_i;
            pend_d[1] = 1'b1;
            if (pend_q[1] && !take1 && (ovr1_q != 8'hFF)) begin
                ovr1_d = ovr1_q + 8'd1;
            end
        end else if (take1) begin
            pend_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold0_q <= '0;
            hold1_q <= '0;
            pend_q  <= 2'b00;
            last_q  <= 1'b1;
            shift_q <= '0;
            idx_q   <= '0;
            csum_q  <= 8'h00;
            din_q   <= 8'h00;
            start_q <= 1'b0;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            ovr0_q  <= 8'h00;
            ovr1_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            din_q   <= din_d;
            start_q <= start_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ovr0_q  <= ovr0_d;
            ovr1_q  <= ovr1_d;
        end
    end

    assign grant_o    = grant_q;
    assign tx_din_o   = din_q;
    assign tx_start_o = start_q;
    assign busy_o     = busy_q;
    assign overrun0_o = ovr0_q;
    assign overrun1_o = ovr1_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: table of single frames plus
// hand-written arbitration, overrun, coincidence and reset sequences.
module tb_uart_frame_arbiter;

    localparam int NB = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        tick = 1'b0;
    logic [47:0] data0 = '0;
    logic [47:0] data1 = '0;
    logic [1:0]  grant_o;
    logic [7:0]  tx_din_o;
    logic        tx_start_o;
    logic        busy_o;
    logic [7:0]  overrun0_o;
    logic [7:0]  overrun1_o;

    uart_frame_arbiter #(.P_NBYTES(NB), .P_SYNC(8'hA5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_i         (req0),
        .data0_i        (data0),
        .req1_i         (req1),
        .data1_i        (data1),
        .grant_o        (grant_o),
        .tx_din_o       (tx_din_o),
        .tx_start_o     (tx_start_o),
        .tx_done_tick_i (tick),
        .busy_o         (busy_o),
        .overrun0_o     (overrun0_o),
        .overrun1_o     (overrun1_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          src;
        logic [47:0] data;
        logic [7:0]  hdr;
        logic [7:0]  csum;
    } vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         g0 = 0;
    int         g1 = 0;
    int         first_wait = 0;
    logic [7:0] exp_b [8];
    vec_t       vecs [6];

    always @(negedge clk) begin
        if (grant_o[0]) g0++;
        if (grant_o[1]) g1++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_exp(input logic [7:0] hdr, input logic [47:0] d, input logic [7:0] cs);
        exp_b[0] = hdr;
        for (int k = 0; k < NB; k++) exp_b[1+k] = d[47-8*k -: 8];
        exp_b[7] = cs;
    endtask

    // uart_tx stand-in: accept nb bytes, tick two cycles after each start
    task automatic recv(input int nb, input string tag);
        int w;
        for (int b = 0; b < nb; b++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!tx_start_o && w < 200);
            if (b == 0) first_wait = w;
            if (!tx_start_o) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s_start_timeout: got no tx_start expected byte %0d", tag, b);
                return;
            end
            chk($sformatf("%s_byte%0d", tag, b), tx_din_o, exp_b[b]);
            @(negedge clk);
            chk($sformatf("%s_startw%0d", tag, b), tx_start_o, 0);
            @(negedge clk);
            chk($sformatf("%s_hold%0d", tag, b), tx_din_o, exp_b[b]);
            chk($sformatf("%s_busy%0d", tag, b), busy_o, 1);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            chk($sformatf("%s_busyafter%0d", tag, b), busy_o, (b == 7) ? 0 : 1);
        end
    endtask

    task automatic pulse_req(input bit s, input logic [47:0] d);
        if (s) begin data1 = d; req1 = 1'b1; end
        else   begin data0 = d; req0 = 1'b1; end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        g0 = 0;
        g1 = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;

        vecs[0] = '{1'b0, 48'h010203040506, 8'hA4, 8'hA3};
        vecs[1] = '{1'b1, 48'hFFFFFFFFFFFF, 8'hA5, 8'hA5};
        vecs[2] = '{1'b0, 48'h000000000000, 8'hA4, 8'hA4};
        vecs[3] = '{1'b1, 48'h123456789ABC, 8'hA5, 8'h8B};
        vecs[4] = '{1'b0, 48'h808080808080, 8'hA4, 8'hA4};
        vecs[5] = '{1'b1, 48'h010204081020, 8'hA5, 8'h9A};

        // reset values
        @(negedge clk);
        chk("rst_grant", grant_o, 0);
        chk("rst_din", tx_din_o, 0);
        chk("rst_start", tx_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovr0", overrun0_o, 0);
        chk("rst_ovr1", overrun1_o, 0);
        do_reset();

        // single frames, with request-to-start latency
        for (int i = 0; i < 6; i++) begin
            set_exp(vecs[i].hdr, vecs[i].data, vecs[i].csum);
            pulse_req(vecs[i].src, vecs[i].data);
            chk($sformatf("v%0d_nogrant", i), grant_o, 0);
            @(negedge clk);
            chk($sformatf("v%0d_grant", i), grant_o, vecs[i].src ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_busy", i), busy_o, 1);
            @(negedge clk);
            chk($sformatf("v%0d_hdr_early", i), tx_din_o, vecs[i].hdr);
            chk($sformatf("v%0d_nostart", i), tx_start_o, 0);
            recv(8, $sformatf("v%0d", i));
            chk($sformatf("v%0d_first_wait", i), first_wait, 1);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_idle_start", i), tx_start_o, 0);
        end
        chk("tbl_g0", g0, 3);
        chk("tbl_g1", g1, 3);

        // simultaneous requests from reset: src0 first
        do_reset();
        data0 = 48'h010203040506;
        data1 = 48'hFFFFFFFFFFFF;
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        chk("both_grant", grant_o, 2'b01);
        set_exp(8'hA4, 48'h010203040506, 8'hA3);
        recv(8, "both_f0");
        set_exp(8'hA5, 48'hFFFFFFFFFFFF, 8'hA5);
        recv(8, "both_f1");
        repeat (2) @(negedge clk);
        chk("both_g0", g0, 1);
        chk("both_g1", g1, 1);
        chk("both_ovr0", overrun0_o, 0);
        chk("both_ovr1", overrun1_o, 0);

        // overwrite of a pending src0 frame while src1 is in flight
        do_reset();
        pulse_req(1'b1, 48'h123456789ABC);
        set_exp(8'hA5, 48'h123456789ABC, 8'h8B);
        fork
            recv(8, "ovr_f1");
            begin
                repeat (3) @(negedge clk);
                pulse_req(1'b0, 48'hAAAAAAAAAAAA);
                repeat (9) @(negedge clk);
                pulse_req(1'b0, 48'h010204081020);
            end
        join
        chk("ovr_cnt0", overrun0_o, 1);
        set_exp(8'hA4, 48'h010204081020, 8'h9B);
        recv(8, "ovr_f0");
        repeat (2) @(negedge clk);
        chk("ovr_g0", g0, 1);
        chk("ovr_cnt0_after", overrun0_o, 1);
        chk("ovr_cnt1", overrun1_o, 0);

        // saturation: src1 stuck in WAIT, src0 overwritten 300 times
        do_reset();
        pulse_req(1'b1, 48'hFFFFFFFFFFFF);
        repeat (3) @(negedge clk);
        data0 = 48'h111111111111;
        req0 = 1'b1;
        for (int i = 1; i <= 301; i++) begin
            @(negedge clk);
            if (i == 101) chk("sat_100", overrun0_o, 100);
            if (i == 255) chk("sat_254", overrun0_o, 254);
            if (i == 256) chk("sat_255", overrun0_o, 255);
        end
        req0 = 1'b0;
        chk("sat_301", overrun0_o, 255);
        chk("sat_busy", busy_o, 1);
        do_reset();
        chk("sat_rst", overrun0_o, 0);

        // request on its own selection edge
        data0 = 48'h010203040506;
        req0 = 1'b1;
        @(negedge clk);
        data0 = 48'h0A0B0C0D0E0F;
        @(negedge clk);
        req0 = 1'b0;
        chk("coin_grant", grant_o, 2'b01);
        set_exp(8'hA4, 48'h010203040506, 8'hA3);
        recv(8, "coin_f1");
        set_exp(8'hA4, 48'h0A0B0C0D0E0F, 8'hA5);
        recv(8, "coin_f2");
        repeat (2) @(negedge clk);
        chk("coin_ovr0", overrun0_o, 0);
        chk("coin_g0", g0, 2);

        // reset during the 4th payload byte
        do_reset();
        set_exp(8'hA4, 48'h010203040506, 8'hA3);
        pulse_req(1'b0, 48'h010203040506);
        recv(4, "mid");
        starts = 0;
        while (!tx_start_o && starts < 200) begin
            @(negedge clk);
            starts++;
        end
        chk("mid_byte4", tx_din_o, 8'h04);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant_o, 0);
        chk("mid_rst_din", tx_din_o, 0);
        chk("mid_rst_start", tx_start_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ovr0", overrun0_o, 0);
        chk("mid_rst_ovr1", overrun1_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick = (i % 3 == 0);
            @(negedge clk);
            if (tx_start_o) starts++;
        end
        tick = 1'b0;
        chk("post_rst_starts", starts, 0);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_din", tx_din_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
